// File: rtl/usb_pulpino_pkg.sv
// usb_pulpino_pkg
// Shared definitions for the USB <-> PULPino GPIO mailbox:
//   - default word width and FIFO depth
//   - state encoding of the host-to-PULPino presentation FSM
package usb_pulpino_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 4;

    typedef enum logic {
        EMPTY    = 1'b0,   // nothing presented to the PULPino
        WAIT_ACK = 1'b1    // a word is presented, waiting for the ack flicker
    } h2p_state_t;

endpackage

// File: rtl/mailbox_fifo.sv
// mailbox_fifo
// Single-clock first-word-fall-through FIFO used once per mailbox direction.
// A push while full is refused even if a pop happens in the same cycle.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_push, i_wdata  push strobe and data (ignored while full)
//   i_pop            pop strobe (ignored while empty)
//   o_rdata          head word; holds the last popped word while empty
//   o_full, o_empty  status flags
//   o_count          occupancy, 0..pDEPTH
module mailbox_fifo #(
    parameter int pWIDTH = 8,
    parameter int pDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [pWIDTH-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [pWIDTH-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(pDEPTH):0]    o_count
);

    localparam int AW = $clog2(pDEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(pDEPTH);

    logic [pWIDTH-1:0] r_mem [pDEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [pWIDTH-1:0] r_last;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // NOTE: the storage array has no reset; pointers and count define validity,
    // so resetting it would only add a reset net to every bit.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Fall-through head; when empty, keep showing the last word read out.
    assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];

endmodule

// File: rtl/usb_pulpino_mailbox.sv
// usb_pulpino_mailbox
// Two-direction mailbox between the USB register side and the PULPino GPIOs.
// Both sides share clk; handshakes to the PULPino use toggle ("flicker")
// signals, an event being any change from the previous cycle's value.
// Ports:
//   clk, reset_i                         clock, async active-high reset
//   h2p_wdata/h2p_wr/h2p_full/h2p_count  host push side of the H2P FIFO
//   p2h_rdata/p2h_rd/p2h_valid/p2h_count host pop side of the P2H FIFO
//   pul_h2p_data, pul_h2p_avail_flicker  word presented to PULPino + toggle
//   pul_h2p_ack_flicker                  PULPino consumed-word toggle
//   pul_p2h_data, pul_p2h_write_flicker  PULPino word + new-word toggle
//   pul_p2h_ack_flicker                  toggles per captured word
//   err_clear                            clears sticky flags (set wins)
//   h2p_overflow, p2h_overrun, ack_spurious  sticky error flags
module usb_pulpino_mailbox
    import usb_pulpino_pkg::*;
#(
    parameter int pDATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int pDEPTH      = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic [pDATA_WIDTH-1:0]    h2p_wdata,
    input  logic                      h2p_wr,
    output logic                      h2p_full,
    output logic [$clog2(pDEPTH):0]   h2p_count,
    output logic [pDATA_WIDTH-1:0]    p2h_rdata,
    input  logic                      p2h_rd,
    output logic                      p2h_valid,
    output logic [$clog2(pDEPTH):0]   p2h_count,
    output logic [pDATA_WIDTH-1:0]    pul_h2p_data,
    output logic                      pul_h2p_avail_flicker,
    input  logic                      pul_h2p_ack_flicker,
    input  logic [pDATA_WIDTH-1:0]    pul_p2h_data,
    input  logic                      pul_p2h_write_flicker,
    output logic                      pul_p2h_ack_flicker,
    input  logic                      err_clear,
    output logic                      h2p_overflow,
    output logic                      p2h_overrun,
    output logic                      ack_spurious
);

    h2p_state_t               r_h2p_state;
    h2p_state_t               w_h2p_state_next;
    logic                     r_ack_prev;
    logic                     r_wr_prev;
    logic [pDATA_WIDTH-1:0]   r_pul_h2p_data;
    logic                     r_avail_flk;
    logic                     r_p2h_ack_flk;
    logic                     r_pend_valid;
    logic [pDATA_WIDTH-1:0]   r_pend_data;
    logic                     r_h2p_overflow;
    logic                     r_p2h_overrun;
    logic                     r_ack_spurious;

    logic                     w_ack_evt;
    logic                     w_wr_evt;
    logic                     w_h2p_empty;
    logic [pDATA_WIDTH-1:0]   w_h2p_head;
    logic                     w_h2p_present;
    logic                     w_h2p_pop;
    logic                     w_spurious_evt;
    logic                     w_p2h_full;
    logic                     w_p2h_empty;
    logic                     w_p2h_push;
    logic [pDATA_WIDTH-1:0]   w_p2h_push_data;
    logic                     w_pend_load;
    logic                     w_pend_clear;
    logic                     w_overrun_evt;

    assign w_ack_evt = (pul_h2p_ack_flicker != r_ack_prev);
    assign w_wr_evt  = (pul_p2h_write_flicker != r_wr_prev);

    mailbox_fifo #(.pWIDTH(pDATA_WIDTH), .pDEPTH(pDEPTH)) u_h2p_fifo (
        .clk     (clk),
        .rst     (reset_i),
        .i_push  (h2p_wr),
        .i_wdata (h2p_wdata),
        .i_pop   (w_h2p_pop),
        .o_rdata (w_h2p_head),
        .o_full  (h2p_full),
        .o_empty (w_h2p_empty),
        .o_count (h2p_count)
    );

    mailbox_fifo #(.pWIDTH(pDATA_WIDTH), .pDEPTH(pDEPTH)) u_p2h_fifo (
        .clk     (clk),
        .rst     (reset_i),
        .i_push  (w_p2h_push),
        .i_wdata (w_p2h_push_data),
        .i_pop   (p2h_rd),
        .o_rdata (p2h_rdata),
        .o_full  (w_p2h_full),
        .o_empty (w_p2h_empty),
        .o_count (p2h_count)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_h2p_state_next = r_h2p_state;
        w_h2p_present    = 1'b0;
        w_h2p_pop        = 1'b0;
        w_spurious_evt   = 1'b0;
        case (r_h2p_state)
            EMPTY: begin
                // An ack with nothing presented only raises the flag.
                w_spurious_evt = w_ack_evt;
                if (!w_h2p_empty) begin
                    w_h2p_present    = 1'b1;
                    w_h2p_state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (w_ack_evt) begin
                    w_h2p_pop        = 1'b1;
                    w_h2p_state_next = EMPTY;
                end
            end
            default: w_h2p_state_next = EMPTY;
        endcase
    end

    // PULPino-to-host capture. A waiting pending word has priority for the
    // FIFO slot; any write event while it waits is an overrun.
    always_comb begin
        w_p2h_push      = 1'b0;
        w_p2h_push_data = pul_p2h_data;
        w_pend_load     = 1'b0;
        w_pend_clear    = 1'b0;
        w_overrun_evt   = 1'b0;
        if (r_pend_valid) begin
            w_p2h_push_data = r_pend_data;
            w_overrun_evt   = w_wr_evt;
            if (!w_p2h_full) begin
                w_p2h_push   = 1'b1;
                w_pend_clear = 1'b1;
            end
        end else if (w_wr_evt) begin
            if (!w_p2h_full) begin
                w_p2h_push = 1'b1;
            end else begin
                w_pend_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_h2p_state    <= EMPTY;
            r_ack_prev     <= 1'b0;
            r_wr_prev      <= 1'b0;
            r_pul_h2p_data <= '0;
            r_avail_flk    <= 1'b0;
            r_p2h_ack_flk  <= 1'b0;
            r_pend_valid   <= 1'b0;
            r_pend_data    <= '0;
            r_h2p_overflow <= 1'b0;
            r_p2h_overrun  <= 1'b0;
            r_ack_spurious <= 1'b0;
        end else begin
            r_h2p_state <= w_h2p_state_next;
            r_ack_prev  <= pul_h2p_ack_flicker;
            r_wr_prev   <= pul_p2h_write_flicker;

            if (w_h2p_present) begin
                r_pul_h2p_data <= w_h2p_head;
                r_avail_flk    <= ~r_avail_flk;
            end

            // Every word entering the P2H FIFO is acknowledged on that edge.
            if (w_p2h_push) begin
                r_p2h_ack_flk <= ~r_p2h_ack_flk;
            end

            if (w_pend_load) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= pul_p2h_data;
            end else if (w_pend_clear) begin
                r_pend_valid <= 1'b0;
            end

            // Sticky flags: a new event in the clearing cycle keeps the flag.
            r_h2p_overflow <= (r_h2p_overflow & ~err_clear) | (h2p_wr & h2p_full);
            r_p2h_overrun  <= (r_p2h_overrun  & ~err_clear) | w_overrun_evt;
            r_ack_spurious <= (r_ack_spurious & ~err_clear) | w_spurious_evt;
        end
    end

    assign p2h_valid             = !w_p2h_empty;
    assign pul_h2p_data          = r_pul_h2p_data;
    assign pul_h2p_avail_flicker = r_avail_flk;
    assign pul_p2h_ack_flicker   = r_p2h_ack_flk;
    assign h2p_overflow          = r_h2p_overflow;
    assign p2h_overrun           = r_p2h_overrun;
    assign ack_spurious          = r_ack_spurious;

endmodule
